// File: rtl/ysyx_23060061_pkg.sv
// Shared types and constants for the NPC instruction fetch unit.
// Optional feature macro: YSYX_23060061_IFU_MISALIGN_CHK_EN (misaligned-fetch trap).
package ysyx_23060061_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } ifuStateT;

    typedef enum logic [1:0] {
        PC_PLUS4,
        PC_REDIRECT,
        PC_PENDING
    } pcSelT;

endpackage

// File: rtl/ysyx_23060061_pc_reg.sv
// Architectural PC register with its next-PC mux (+4, redirect target, deferred target).
// The selected next value is also exported so the fetch FSM can inspect it before loading.
module ysyx_23060061_pc_reg
    import ysyx_23060061_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  pcSelT           sel,
    input  logic [XLEN-1:0] redirectPc,
    input  logic [XLEN-1:0] pendingPc,
    output logic [XLEN-1:0] nextPc,
    output logic [XLEN-1:0] pc
);

    // Pick the candidate next PC; sequential fall-through wraps modulo 2^XLEN.
    always_comb begin
        nextPc = pc + XLEN'(4);
        case (sel)
            PC_PLUS4:    nextPc = pc + XLEN'(4);
            PC_REDIRECT: nextPc = redirectPc;
            PC_PENDING:  nextPc = pendingPc;
            default:     nextPc = pc + XLEN'(4);
        endcase
    end

    // Hold the PC, loading the selected candidate only when the FSM asks for it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= nextPc;
        end
    end

endmodule

// File: rtl/ysyx_23060061_ifu.sv
// Instruction fetch unit: owns the PC, issues one word fetch at a time and hands the
// word to the decoder under valid/ready. Redirects that land while a fetch is in flight
// are deferred (kill + pendingPc) until the stale response has been drained.
// Optional feature macro: YSYX_23060061_IFU_MISALIGN_CHK_EN -- when defined, a fetch
// from a non-word-aligned PC is not sent to memory and a faulting nop is delivered.
module ysyx_23060061_ifu
    import ysyx_23060061_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            fetch_fault
);

    ifuStateT        state;
    logic            kill;
    logic [XLEN-1:0] pendingPc;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] nextPc;
    logic [XLEN-1:0] fetchPc;
    logic            pcLoad;
    pcSelT           pcSel;
    logic            startFetch;
    logic            fetchMisaligned;

    ysyx_23060061_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) pcReg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (pcLoad),
        .sel        (pcSel),
        .redirectPc (redirect_pc),
        .pendingPc  (pendingPc),
        .nextPc     (nextPc),
        .pc         (pc)
    );

    // Decide whether a new fetch begins this cycle and which PC it will use.
    always_comb begin
        startFetch = 1'b0;
        pcLoad     = 1'b0;
        pcSel      = PC_PLUS4;
        case (state)
            IDLE: begin
                startFetch = 1'b1;
                if (redirect_valid) begin
                    pcLoad = 1'b1;
                    pcSel  = PC_REDIRECT;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    startFetch = 1'b1;
                    pcLoad     = 1'b1;
                    pcSel      = PC_REDIRECT;
                end else if (inst_ready) begin
                    startFetch = 1'b1;
                    pcLoad     = 1'b1;
                    pcSel      = PC_PLUS4;
                end
            end
            WAIT: begin
                if (imem_rsp_valid && (kill || redirect_valid)) begin
                    startFetch = 1'b1;
                    pcLoad     = 1'b1;
                    pcSel      = redirect_valid ? PC_REDIRECT : PC_PENDING;
                end
            end
            default: begin
                startFetch = 1'b0;
            end
        endcase
    end

    assign fetchPc = pcLoad ? nextPc : pc;

`ifdef YSYX_23060061_IFU_MISALIGN_CHK_EN
    logic fetchFaultQ;
    assign fetchMisaligned = (fetchPc[1:0] != 2'b00);
    assign imem_req_addr   = pc;
    assign fetch_fault     = fetchFaultQ;
`else
    assign fetchMisaligned = 1'b0;
    assign imem_req_addr   = {pc[XLEN-1:2], 2'b00};
    assign fetch_fault     = 1'b0;
`endif

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];

    // Fetch FSM with registered handshake outputs and deferred-redirect bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            kill           <= 1'b0;
            pendingPc      <= RESET_PC;
            imem_req_valid <= 1'b0;
            inst_valid     <= 1'b0;
            inst           <= '0;
            inst_pc        <= '0;
`ifdef YSYX_23060061_IFU_MISALIGN_CHK_EN
            fetchFaultQ    <= 1'b0;
`endif
        end else if (startFetch) begin
            kill <= 1'b0;
            if (fetchMisaligned) begin
                state          <= HOLD;
                imem_req_valid <= 1'b0;
                inst_valid     <= 1'b1;
                inst           <= XLEN'(NOP_INST);
                inst_pc        <= fetchPc;
            end else begin
                state          <= REQ;
                imem_req_valid <= 1'b1;
                inst_valid     <= 1'b0;
            end
`ifdef YSYX_23060061_IFU_MISALIGN_CHK_EN
            fetchFaultQ <= fetchMisaligned;
`endif
        end else begin
            case (state)
                REQ: begin
                    if (redirect_valid) begin
                        kill      <= 1'b1;
                        pendingPc <= redirect_pc;
                    end
                    if (imem_req_ready) begin
                        state          <= WAIT;
                        imem_req_valid <= 1'b0;
                    end
                end
                WAIT: begin
                    if (redirect_valid) begin
                        kill      <= 1'b1;
                        pendingPc <= redirect_pc;
                    end
                    if (imem_rsp_valid) begin
                        inst       <= imem_rsp_data;
                        inst_pc    <= pc;
                        inst_valid <= 1'b1;
                        state      <= HOLD;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060061_ifu.sv
// Directed self-checking bench for the NPC instruction fetch unit.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ysyx_23060061_ifu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_fault;

    int compareCount  = 0;
    int mismatchCount = 0;

    ysyx_23060061_ifu dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .opcode         (opcode),
        .funct3         (funct3),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, then advance to the next falling edge.
    task automatic applyStimulus(input logic reqReady, input logic rspValid, input logic [31:0] rspData,
                                 input logic instReady, input logic redirValid, input logic [31:0] redirPc);
        imem_req_ready = reqReady;
        imem_rsp_valid = rspValid;
        imem_rsp_data  = rspData;
        inst_ready     = instReady;
        redirect_valid = redirValid;
        redirect_pc    = redirPc;
        @(negedge clk);
    endtask

    // From REQ: accept the request, return the word, and check the decoder-side view.
    task automatic fetchWord(input logic [31:0] expAddr, input logic [31:0] expPc, input logic [31:0] data);
        logic [31:0] expOpcode;
        logic [31:0] expFunct3;
        expOpcode = {25'd0, data[6:0]};
        expFunct3 = {29'd0, data[14:12]};
        checkOutput("reqValid", {31'd0, imem_req_valid}, 32'd1);
        checkOutput("reqAddr", imem_req_addr, expAddr);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("waitReqValid", {31'd0, imem_req_valid}, 32'd0);
        checkOutput("waitInstValid", {31'd0, inst_valid}, 32'd0);
        applyStimulus(1'b0, 1'b1, data, 1'b0, 1'b0, 32'h0);
        checkOutput("instValid", {31'd0, inst_valid}, 32'd1);
        checkOutput("inst", inst, data);
        checkOutput("instPc", inst_pc, expPc);
        checkOutput("opcode", {25'd0, opcode}, expOpcode);
        checkOutput("funct3", {29'd0, funct3}, expFunct3);
    endtask

    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        @(negedge clk);
        @(negedge clk);

        // Reset values
        checkOutput("rstReqValid", {31'd0, imem_req_valid}, 32'd0);
        checkOutput("rstInstValid", {31'd0, inst_valid}, 32'd0);
        checkOutput("rstInst", inst, 32'h0);
        checkOutput("rstInstPc", inst_pc, 32'h0);
        checkOutput("rstOpcode", {25'd0, opcode}, 32'h0);
        checkOutput("rstFunct3", {29'd0, funct3}, 32'h0);
        checkOutput("rstFault", {31'd0, fetch_fault}, 32'd0);

        // Release: one IDLE cycle, then the first request
        rst_n = 1'b1;
        #1;
        checkOutput("idleReqValid", {31'd0, imem_req_valid}, 32'd0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        // Zero-wait stream of three instructions
        fetchWord(32'h8000_0000, 32'h8000_0000, 32'h0010_0093);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checkOutput("consumedInstValid", {31'd0, inst_valid}, 32'd0);
        fetchWord(32'h8000_0004, 32'h8000_0004, 32'h0000_7033);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        fetchWord(32'h8000_0008, 32'h8000_0008, 32'h1234_5677);

        // Decoder stall for five cycles
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            checkOutput("stallInstValid", {31'd0, inst_valid}, 32'd1);
            checkOutput("stallInstPc", inst_pc, 32'h8000_0008);
            checkOutput("stallInst", inst, 32'h1234_5677);
            checkOutput("stallReqValid", {31'd0, imem_req_valid}, 32'd0);
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checkOutput("releaseInstValid", {31'd0, inst_valid}, 32'd0);

        // Redirect during WAIT drops the in-flight word
        checkOutput("reqAddrC", imem_req_addr, 32'h8000_000C);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0100);
        checkOutput("killWaitReqValid", {31'd0, imem_req_valid}, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        checkOutput("killInstValid", {31'd0, inst_valid}, 32'd0);
        checkOutput("killReqValid", {31'd0, imem_req_valid}, 32'd1);
        checkOutput("killReqAddr", imem_req_addr, 32'h8000_0100);

        // Redirects during REQ: address stays put, last target wins
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0300);
        checkOutput("stableReqAddr", imem_req_addr, 32'h8000_0100);
        checkOutput("stableReqValid", {31'd0, imem_req_valid}, 32'd1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0400);
        applyStimulus(1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0);
        checkOutput("lastWinsInstValid", {31'd0, inst_valid}, 32'd0);
        fetchWord(32'h8000_0400, 32'h8000_0400, 32'h0000_0013);

        // Redirect coinciding with a HOLD handshake beats +4
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8000_0200);
        checkOutput("hsRedirInstValid", {31'd0, inst_valid}, 32'd0);
        fetchWord(32'h8000_0200, 32'h8000_0200, 32'h0041_2283);

        // Redirect to a misaligned target
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0102);
`ifdef YSYX_23060061_IFU_MISALIGN_CHK_EN
        checkOutput("misReqValid", {31'd0, imem_req_valid}, 32'd0);
        checkOutput("misInstValid", {31'd0, inst_valid}, 32'd1);
        checkOutput("misInst", inst, 32'h0000_0013);
        checkOutput("misInstPc", inst_pc, 32'h8000_0102);
        checkOutput("misFault", {31'd0, fetch_fault}, 32'd1);
`else
        checkOutput("misFault", {31'd0, fetch_fault}, 32'd0);
        fetchWord(32'h8000_0100, 32'h8000_0102, 32'h0000_2003);
`endif
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0300);
        checkOutput("faultCleared", {31'd0, fetch_fault}, 32'd0);
        checkOutput("postMisInstValid", {31'd0, inst_valid}, 32'd0);
        checkOutput("postMisReqAddr", imem_req_addr, 32'h8000_0300);

        // Reset in the middle of a fetch; a late response is ignored
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b0;
        #1;
        checkOutput("midRstReqValid", {31'd0, imem_req_valid}, 32'd0);
        checkOutput("midRstInst", inst, 32'h0);
        checkOutput("midRstInstPc", inst_pc, 32'h0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        checkOutput("lateRspInstValid", {31'd0, inst_valid}, 32'd0);
        checkOutput("lateRspInst", inst, 32'h0);
        checkOutput("lateRspReqAddr", imem_req_addr, 32'h8000_0000);
        checkOutput("lateRspReqValid", {31'd0, imem_req_valid}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/ysyx_23060061_ifu.md
# ysyx_23060061_ifu

Instruction fetch unit for the NPC core. It sits directly upstream of the instruction decoder and owns the architectural PC. It issues one word fetch at a time to instruction memory over a valid/ready request channel plus a response channel. It presents the fetched word, its PC and the pre-sliced `opcode`/`funct3` fields to the decoder under a valid/ready handshake, and accepts control-flow redirects from the execute/write-back side.

## Interface
- `RESET_PC`, 32'h8000_0000: PC loaded on reset.
- `XLEN`, 32: PC, address and instruction width.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `imem_req_valid`  out  1  fetch request pending.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_req_addr`  out  XLEN  fetch address.
- `imem_rsp_valid`  in  1  response word valid; always accepted, no back-pressure.
- `imem_rsp_data`  in  XLEN  fetched instruction.
- `inst_valid`  out  1  instruction available to the decoder.
- `inst_ready`  in  1  decoder consumes the instruction.
- `inst`  out  XLEN  instruction word.
- `inst_pc`  out  XLEN  PC of `inst`.
- `opcode`  out  7  `inst[6:0]`.
- `funct3`  out  3  `inst[14:12]`.
- `redirect_valid`  in  1  one-cycle pulse that replaces the next PC.
- `redirect_pc`  in  XLEN  redirect target.
- `fetch_fault`  out  1  misaligned fetch flag. Tied to 0 when the feature is compiled out.

## Operation
- FSM states:
  - IDLE: one cycle after reset, always goes to REQ.
  - REQ: `imem_req_valid`=1, addr=`pc`. On `imem_req_ready` go to WAIT.
  - WAIT: on `imem_rsp_valid`, latch data into `inst`, set `inst_pc`=`pc`, go to HOLD.
  - HOLD: `inst_valid`=1. On `inst_ready`, `pc`←`pc`+4 (mod 2^32) and go to REQ.
- At most one outstanding request.
- `imem_req_addr` stays stable while `imem_req_valid`=1 and not yet accepted.
- Redirect handling:
  - In IDLE or HOLD: `pc`←`redirect_pc`, go to REQ. A held instruction is dropped with no handshake; `inst_valid` falls the next cycle.
  - In HOLD coinciding with `inst_ready`: the instruction counts as consumed, the redirect wins over +4, and `pc`←`redirect_pc`.
  - In REQ or WAIT: set `kill`, store the target in `pending_pc`, and let the in-flight request complete. When its response arrives it is discarded, `pc`←`pending_pc`, `kill` clears, and the FSM goes to REQ, skipping HOLD.
  - A second redirect while `kill`=1 overwrites `pending_pc`; the last one wins.
- `opcode`/`funct3` are combinational slices of the `inst` register.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, state IDLE, `kill`=0.
  - `imem_req_valid`=0, `inst_valid`=0, `inst`=0, `inst_pc`=0, `fetch_fault`=0.
  - `opcode`=0, `funct3`=0.
- First `imem_req_valid` appears in the 2nd cycle after `rst_n` deasserts.
- Best case with ready=1 in cycle N and the response in N+1: `inst_valid`=1 in N+2.
- Steady state, zero-wait: 3 cycles per instruction (REQ, WAIT, HOLD).
- Redirect latency from HOLD or IDLE: request to `redirect_pc` in the next cycle.
- Reset asserted mid-transaction: return to reset values immediately. A late memory response after reset is ignored because the FSM is not in WAIT.

## Configuration
- `YSYX_23060061_IFU_MISALIGN_CHK_EN` defined:
  - On entry to REQ with `pc[1:0]`≠0, no memory request is issued.
  - The FSM goes straight to HOLD with `inst`=32'h0000_0013 (nop), `inst_pc`=`pc`, `fetch_fault`=1.
  - `fetch_fault` clears on consumption or redirect.
- Undefined:
  - `imem_req_addr`={`pc`[31:2], 2'b00}.
  - `fetch_fault` is tied to 0.

## Structure
- Package `ysyx_23060061_pkg` holds:
  - IFU state enum (IDLE/REQ/WAIT/HOLD).
  - `NOP_INST` constant.
  - `RESET_PC` default.
- One sub-module, `ysyx_23060061_pc_reg`: async-reset PC register with load-enable and next-PC mux (+4 / redirect / pending).

## Test plan
- Reset release, memory ready=1, 1-cycle response, `inst_ready`=1: requests at 0x80000000, 0x80000004, 0x80000008; `inst_valid` every 3rd cycle with matching `inst_pc`.
- Response 0x00100093: `opcode`=7'h13, `funct3`=3'b000 while `inst_valid`=1.
- `inst_ready` held 0 for 5 cycles: `inst`/`inst_pc` stable, no new request; release gives exactly one handshake.
- Redirect to 0x80000100 during WAIT: in-flight response is discarded with no `inst_valid`; next request goes to 0x80000100.
- Redirect to 0x80000200 in the same cycle as a HOLD handshake: next request goes to 0x80000200, not `pc`+4.
- Misalign feature on, redirect to 0x80000102: no memory request; `inst`=0x13, `fetch_fault`=1, `inst_pc`=0x80000102.
